// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- board demo: Gray-code switch decoder, fixed Hamming(7,4)
// encode/corrupt/correct loop, and two-digit decimal 7-segment display.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ag, bg, cg, dg         Gray-code switches (ag = MSB), async to clk
//   sw_rx                  reserved, ignored
//   sw_mode                0 = show decoded switches, 1 = show corrected nibble
//   led[3:0]               selected value, registered
//   au..gu / ad..gd        units / tens segments a..g, active-high, registered
// ---------------------------------------------------------------------------

// Two-flop synchronizer lane for one asynchronous input bit.
module top_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;
endmodule

module top #(
  parameter logic [3:0] DEMO_DATA = 4'hA,
  parameter int         ERR_POS   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ag,
  input  logic bg,
  input  logic cg,
  input  logic dg,
  input  logic sw_rx,
  input  logic sw_mode,
  output logic [3:0] led,
  output logic au, bu, cu, du, eu, fu, gu,
  output logic ad, bd, cd, dd, ed, fd, gd
);
  localparam int NUM_LANES = 5;

  // sw_rx is reserved; tie it off so it has no effect.
  logic unused_sw_rx;
  assign unused_sw_rx = sw_rx;

  // ---- synchronizers: lanes {sw_mode, ag, bg, cg, dg} ----
  logic [NUM_LANES-1:0] async_in, sync_out;
  assign async_in = {sw_mode, ag, bg, cg, dg};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sync
    top_sync u_sync (.clk(clk), .rst_n(rst_n), .d(async_in[i]), .q(sync_out[i]));
  end

  logic       mode_s;
  logic [3:0] gray_s;
  assign mode_s = sync_out[4];
  assign gray_s = sync_out[3:0];

  // ---- Gray to binary ----
  logic [3:0] bin;
  always_comb begin
    bin[3] = gray_s[3];
    bin[2] = bin[3] ^ gray_s[2];
    bin[1] = bin[2] ^ gray_s[1];
    bin[0] = bin[1] ^ gray_s[0];
  end

  // ---- Hamming(7,4) loop; constant-folds since inputs are parameters ----
  logic [7:1] cw;
  logic [2:0] syn;
  logic [3:0] corrected;
  always_comb begin
    cw[3] = DEMO_DATA[0];
    cw[5] = DEMO_DATA[1];
    cw[6] = DEMO_DATA[2];
    cw[7] = DEMO_DATA[3];
    cw[1] = cw[3] ^ cw[5] ^ cw[7];
    cw[2] = cw[3] ^ cw[6] ^ cw[7];
    cw[4] = cw[5] ^ cw[6] ^ cw[7];
    // Injected channel error (ERR_POS = 0 leaves codeword intact).
    for (int i = 1; i <= 7; i++)
      if (i == ERR_POS) cw[i] = ~cw[i];
    syn[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
    syn[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
    syn[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
    // Syndrome is the 1-based position of the bad bit; 0 means clean.
    for (int i = 1; i <= 7; i++)
      if (i == int'(syn)) cw[i] = ~cw[i];
    corrected = {cw[7], cw[6], cw[5], cw[3]};
  end

  // ---- select and decimal split ----
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [3:0] value, units;
  logic       tens;
  logic [3:0] led_q, led_d;
  logic [6:0] seg_u_q, seg_u_d;
  logic [6:0] seg_t_q, seg_t_d;

  always_comb begin
    value   = mode_s ? corrected : bin;
    tens    = (value >= 4'd10);
    units   = tens ? (value - 4'd10) : value;
    led_d   = value;
    seg_u_d = seg7(units);
    seg_t_d = seg7({3'b000, tens});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      seg_u_q <= '0;
      seg_t_q <= '0;
    end else begin
      led_q   <= led_d;
      seg_u_q <= seg_u_d;
      seg_t_q <= seg_t_d;
    end
  end

  assign led = led_q;
  assign {au, bu, cu, du, eu, fu, gu} = seg_u_q;
  assign {ad, bd, cd, dd, ed, fd, gd} = seg_t_q;
endmodule

// File: tb/tb_top.sv
module tb_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ag = 0, bg = 0, cg = 0, dg = 0, sw_rx = 0, sw_mode = 0;
  logic [3:0] led;
  logic au, bu, cu, du, eu, fu, gu, ad, bd, cd, dd, ed, fd, gd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  top #(.DEMO_DATA(4'hA), .ERR_POS(3)) dut (
    .clk(clk), .rst_n(rst_n), .ag(ag), .bg(bg), .cg(cg), .dg(dg),
    .sw_rx(sw_rx), .sw_mode(sw_mode), .led(led),
    .au(au), .bu(bu), .cu(cu), .du(du), .eu(eu), .fu(fu), .gu(gu),
    .ad(ad), .bd(bd), .cd(cd), .dd(dd), .ed(ed), .fd(fd), .gd(gd)
  );

  // One extra instance per injected error position, sharing all inputs.
  wire [3:0] led_e [8];
  wire [6:0] u_e   [8];
  wire [6:0] t_e   [8];
  for (genvar g = 0; g < 8; g++) begin : g_err
    top #(.DEMO_DATA(4'hA), .ERR_POS(g)) u_e_dut (
      .clk(clk), .rst_n(rst_n), .ag(ag), .bg(bg), .cg(cg), .dg(dg),
      .sw_rx(sw_rx), .sw_mode(sw_mode), .led(led_e[g]),
      .au(u_e[g][6]), .bu(u_e[g][5]), .cu(u_e[g][4]), .du(u_e[g][3]),
      .eu(u_e[g][2]), .fu(u_e[g][1]), .gu(u_e[g][0]),
      .ad(t_e[g][6]), .bd(t_e[g][5]), .cd(t_e[g][4]), .dd(t_e[g][3]),
      .ed(t_e[g][2]), .fd(t_e[g][1]), .gd(t_e[g][0])
    );
  end

  wire [6:0] seg_u = {au, bu, cu, du, eu, fu, gu};
  wire [6:0] seg_t = {ad, bd, cd, dd, ed, fd, gd};

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                         S9 = 7'b1111011;

  typedef struct {
    logic [3:0] gray;
    logic       mode;
    logic       rx;
    logic [3:0] e_led;
    logic [6:0] e_u;
    logic [6:0] e_t;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] gr, input logic m, input logic rx);
    {ag, bg, cg, dg} = gr;
    sw_mode = m;
    sw_rx = rx;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] el,
                            input logic [6:0] eu, input logic [6:0] et);
    check({tag, ".led"}, 32'(led), 32'(el));
    check({tag, ".units"}, 32'(seg_u), 32'(eu));
    check({tag, ".tens"}, 32'(seg_t), 32'(et));
  endtask

  initial begin
    logic [3:0] prev_led;

    vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'd0,  S0, S0});
    vecs.push_back('{4'b1000, 1'b0, 1'b0, 4'd15, S5, S1});
    vecs.push_back('{4'b0100, 1'b0, 1'b0, 4'd7,  S7, S0});
    vecs.push_back('{4'b0010, 1'b0, 1'b0, 4'd3,  S3, S0});
    vecs.push_back('{4'b0001, 1'b0, 1'b0, 4'd1,  S1, S0});
    vecs.push_back('{4'b1100, 1'b0, 1'b0, 4'd8,  S8, S0});
    vecs.push_back('{4'b1101, 1'b0, 1'b1, 4'd9,  S9, S0});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'd10, S0, S1});
    vecs.push_back('{4'b1110, 1'b0, 1'b0, 4'd11, S1, S1});
    vecs.push_back('{4'b1010, 1'b0, 1'b0, 4'd12, S2, S1});
    vecs.push_back('{4'b1011, 1'b0, 1'b0, 4'd13, S3, S1});
    vecs.push_back('{4'b1001, 1'b0, 1'b0, 4'd14, S4, S1});
    vecs.push_back('{4'b0110, 1'b0, 1'b0, 4'd4,  S4, S0});
    vecs.push_back('{4'b0011, 1'b0, 1'b0, 4'd2,  S2, S0});
    vecs.push_back('{4'b0101, 1'b1, 1'b1, 4'd10, S0, S1});
    vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'd10, S0, S1});
    vecs.push_back('{4'b0111, 1'b0, 1'b1, 4'd5,  S5, S0});
    vecs.push_back('{4'b0101, 1'b0, 1'b0, 4'd6,  S6, S0});

    // Reset state with non-zero inputs applied.
    drive(4'b1011, 1'b1, 1'b1);
    tick(2);
    check_outs("reset", 4'd0, 7'd0, 7'd0);

    drive(4'b0000, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    prev_led = 4'd0;

    foreach (vecs[i]) begin
      drive(vecs[i].gray, vecs[i].mode, vecs[i].rx);
      tick(2);
      // Three-edge latency: two edges after the change the old value holds.
      if (prev_led != vecs[i].e_led)
        check($sformatf("v%0d.latency", i), 32'(led), 32'(prev_led));
      tick(1);
      check_outs($sformatf("v%0d", i), vecs[i].e_led, vecs[i].e_u, vecs[i].e_t);
      prev_led = vecs[i].e_led;
    end

    // Demo mode across every ERR_POS, switches and sw_rx arbitrary.
    drive(4'b0110, 1'b1, 1'b1);
    tick(3);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("err%0d.led", k), 32'(led_e[k]), 32'd10);
      check($sformatf("err%0d.units", k), 32'(u_e[k]), 32'(S0));
      check($sformatf("err%0d.tens", k), 32'(t_e[k]), 32'(S1));
    end

    // sw_rx toggling alone leaves outputs untouched.
    for (int k = 0; k < 4; k++) begin
      sw_rx = ~sw_rx;
      tick(1);
      check_outs($sformatf("rx%0d", k), 4'd10, S0, S1);
    end

    // Back to switch mode: Gray 0110 -> binary 4.
    sw_mode = 1'b0;
    tick(2);
    check("mode0.latency", 32'(led), 32'd10);
    tick(1);
    check_outs("mode0", 4'd4, S4, S0);

    // Simultaneous switch and mode change land on the same edge.
    drive(4'b1000, 1'b1, 1'b0);
    tick(2);
    check("simul.latency", 32'(led), 32'd4);
    tick(1);
    check_outs("simul", 4'd10, S0, S1);

    // Mid-cycle reset blanks outputs without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outs("midrst", 4'd0, 7'd0, 7'd0);
    tick(2);
    check_outs("midrst.hold", 4'd0, 7'd0, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("rel.latency", 32'(led), 32'd0);
    tick(1);
    check_outs("rel", 4'd10, S0, S1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
